exec_unit: RTL and testbench

//   Parametrised integer execution unit between the reservation station (RS) and the CDB arbiter.

---
 rtl/exec_pkg.sv | 86 ++++++++
 rtl/exec_unit_mdu_iter.sv | 153 +++++++++++++++
 rtl/exec_unit.sv | 192 +++++++++++++++++++
 tb/tb_exec_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
//   Shared definitions for the integer execution unit: 5-bit opcodes, FSM
//   state encoding and small predicates on opcodes / special operand cases.
// ---------------------------------------------------------------------------
package exec_pkg;

    // Single-cycle ALU / compare opcodes
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_BEQ    = 5'd10;
    localparam logic [4:0] OP_BGE    = 5'd11;
    localparam logic [4:0] OP_BGEU   = 5'd12;
    localparam logic [4:0] OP_BNE    = 5'd13;
    localparam logic [4:0] OP_ADD_PC = 5'd14;

    // Iterative multiply / divide opcodes
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Opcodes 16..23 go through the iterative datapath
    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Opcodes 20..23: DIV DIVU REM REMU
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return is_div_op(op) & op[1];
    endfunction

    // Operand a is interpreted as two's complement
    function automatic logic op_a_signed(input logic [4:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    // Operand b is interpreted as two's complement
    function automatic logic op_b_signed(input logic [4:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

    // Any divide/remainder with a zero divisor
    function automatic logic is_div_by_zero(input logic [4:0] op, input logic b_zero);
        return is_div_op(op) & b_zero;
    endfunction

    // Signed most-negative / -1: quotient does not fit, resolved directly
    function automatic logic is_div_overflow(input logic [4:0] op, input logic a_min,
                                             input logic b_minus_one);
        return ((op == OP_DIV) || (op == OP_REM)) & a_min & b_minus_one;
    endfunction

endpackage

// File: rtl/exec_unit_mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
//   Radix-2 iterative multiply/divide datapath. Works on operand magnitudes:
//   shift-add multiply and restoring divide share the hi/lo register pair.
//   Sign correction and hi/lo / quotient/remainder selection are applied
//   combinationally on the final register contents.
// Ports
//   clk_in, rst_in : clock, asynchronous active-high reset
//   start          : latch operands (magnitudes) and signs, count <= 0
//   step           : perform one radix-2 iteration
//   flush          : abort, count <= 0
//   op, a, b       : opcode and operands sampled on start
//   last           : current step is the final one (count == XLEN-1)
//   result         : sign-corrected selected result after the final step
// ---------------------------------------------------------------------------
module mdu_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start,
    input  logic            step,
    input  logic            flush,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] hi_r;       // mul: accumulator high half / div: partial remainder
    logic [XLEN-1:0] lo_r;       // mul: multiplier -> product low / div: dividend -> quotient
    logic [XLEN-1:0] opnd_r;     // mul: |a| multiplicand / div: |b| divisor
    logic [CW-1:0]   count_r;
    logic [4:0]      op_r;
    logic            neg_main_r; // negate product or quotient
    logic            neg_rem_r;  // negate remainder (follows dividend sign)

    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic            div_ge_s;
    logic [XLEN-1:0] hi_nx_s;
    logic [XLEN-1:0] lo_nx_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0] quot_fix_s;
    logic [XLEN-1:0] rem_fix_s;

    // Operand magnitudes and signs for the start cycle
    always_comb begin
        a_neg_s = op_a_signed(op) & a[XLEN-1];
        b_neg_s = op_b_signed(op) & b[XLEN-1];
        if (a_neg_s) begin
            abs_a_s = (~a) + ONE_X;
        end else begin
            abs_a_s = a;
        end
        if (b_neg_s) begin
            abs_b_s = (~b) + ONE_X;
        end else begin
            abs_b_s = b;
        end
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
        // Remainder < divisor, so the shifted value always fits XLEN+1 bits
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (is_div_op(op_r)) begin
            if (div_ge_s) begin
                hi_nx_s = div_diff_s[XLEN-1:0];
            end else begin
                hi_nx_s = div_shift_s[XLEN-1:0];
            end
            lo_nx_s = {lo_r[XLEN-2:0], div_ge_s};
        end else begin
            hi_nx_s = mul_sum_s[XLEN:1];
            lo_nx_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Iteration registers: load on start, advance on step, count cleared on flush
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hi_r       <= {XLEN{1'b0}};
            lo_r       <= {XLEN{1'b0}};
            opnd_r     <= {XLEN{1'b0}};
            count_r    <= {CW{1'b0}};
            op_r       <= 5'd0;
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else if (flush) begin
            count_r <= {CW{1'b0}};
        end else if (start) begin
            hi_r       <= {XLEN{1'b0}};
            lo_r       <= is_div_op(op) ? abs_a_s : abs_b_s;
            opnd_r     <= is_div_op(op) ? abs_b_s : abs_a_s;
            count_r    <= {CW{1'b0}};
            op_r       <= op;
            neg_main_r <= a_neg_s ^ b_neg_s;
            neg_rem_r  <= a_neg_s;
        end else if (step) begin
            hi_r    <= hi_nx_s;
            lo_r    <= lo_nx_s;
            count_r <= count_r + CW'(1);
        end
    end

    assign last = (count_r == CW'(XLEN-1));

    // Sign correction and result selection
    always_comb begin
        prod_s = {hi_r, lo_r};
        if (neg_main_r) begin
            prod_fix_s = (~prod_s) + ONE_2X;
            quot_fix_s = (~lo_r) + ONE_X;
        end else begin
            prod_fix_s = prod_s;
            quot_fix_s = lo_r;
        end
        if (neg_rem_r) begin
            rem_fix_s = (~hi_r) + ONE_X;
        end else begin
            rem_fix_s = hi_r;
        end
        case (op_r)
            OP_MUL:                       result = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quot_fix_s;
            OP_REM, OP_REMU:              result = rem_fix_s;
            default:                      result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// exec_unit
//   Integer execution unit between the reservation station and the CDB.
//   RV32I ALU / compare ops complete in one cycle; RV32M ops iterate in
//   mdu_iter for XLEN steps plus a fix-up cycle. Divide-by-zero and signed
//   overflow divides are resolved at accept with single-cycle latency.
// Ports
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   rdy_in                : global enable, 0 freezes all state
//   clear                 : flush of in-flight work (qualified by rdy_in)
//   in_valid/in_ready     : RS handshake; in_ready is combinational
//   in_op, in_a, in_b     : opcode and operands
//   in_rs, in_rob         : tags carried to the result
//   out_valid/out_ready   : CDB handshake; out_* held while stalled
//   out_result, out_rs, out_rob : registered result and tags
// ---------------------------------------------------------------------------
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RS_WIDTH  = 2,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [RS_WIDTH-1:0]  in_rs,
    input  logic [ROB_WIDTH-1:0] in_rob,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [RS_WIDTH-1:0]  out_rs,
    output logic [ROB_WIDTH-1:0] out_rob
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] FOUR_X = XLEN'(3'd4);

    state_t                 state_r;
    logic                   out_valid_r;
    logic [XLEN-1:0]        out_result_r;
    logic [RS_WIDTH-1:0]    out_rs_r;
    logic [ROB_WIDTH-1:0]   out_rob_r;
    logic [RS_WIDTH-1:0]    pend_rs_r;
    logic [ROB_WIDTH-1:0]   pend_rob_r;

    logic                   accept_s;
    logic [SHW-1:0]         shamt_s;
    logic [XLEN-1:0]        alu_res_s;
    logic                   b_zero_s;
    logic                   a_min_s;
    logic                   b_m1_s;
    logic                   div0_s;
    logic                   ovf_s;
    logic [XLEN-1:0]        fast_res_s;
    logic                   mdu_start_s;
    logic                   mdu_step_s;
    logic                   mdu_flush_s;
    logic                   mdu_last_s;
    logic [XLEN-1:0]        mdu_res_s;

    assign in_ready = ~rst_in & rdy_in & ~clear & (state_r == S_IDLE)
                    & (~out_valid_r | out_ready);
    assign accept_s = in_valid & in_ready;

    // Single-cycle ALU and compare results
    always_comb begin
        shamt_s = in_b[SHW-1:0];
        case (in_op)
            OP_ADD:    alu_res_s = in_a + in_b;
            OP_SUB:    alu_res_s = in_a - in_b;
            OP_AND:    alu_res_s = in_a & in_b;
            OP_OR:     alu_res_s = in_a | in_b;
            OP_XOR:    alu_res_s = in_a ^ in_b;
            OP_SLL:    alu_res_s = in_a << shamt_s;
            OP_SRL:    alu_res_s = in_a >> shamt_s;
            OP_SRA:    alu_res_s = $unsigned($signed(in_a) >>> shamt_s);
            OP_SLT:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU:   alu_res_s = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            OP_BEQ:    alu_res_s = {{(XLEN-1){1'b0}}, (in_a == in_b)};
            OP_BGE:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in_a) >= $signed(in_b))};
            OP_BGEU:   alu_res_s = {{(XLEN-1){1'b0}}, (in_a >= in_b)};
            OP_BNE:    alu_res_s = {{(XLEN-1){1'b0}}, (in_a != in_b)};
            OP_ADD_PC: alu_res_s = in_a + in_b - FOUR_X;
            default:   alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Divide special cases bypass the iteration and finish in one cycle
    always_comb begin
        b_zero_s = (in_b == {XLEN{1'b0}});
        a_min_s  = (in_a == {1'b1, {(XLEN-1){1'b0}}});
        b_m1_s   = &in_b;
        div0_s   = is_div_by_zero(in_op, b_zero_s);
        ovf_s    = is_div_overflow(in_op, a_min_s, b_m1_s);
        if (div0_s) begin
            fast_res_s = is_rem_op(in_op) ? in_a : {XLEN{1'b1}};
        end else if (ovf_s) begin
            fast_res_s = is_rem_op(in_op) ? {XLEN{1'b0}} : in_a;
        end else begin
            fast_res_s = alu_res_s;
        end
    end

    assign mdu_start_s = rdy_in & accept_s & is_mdu_op(in_op) & ~div0_s & ~ovf_s;
    assign mdu_step_s  = rdy_in & ~clear & (state_r == S_ITER);
    assign mdu_flush_s = rdy_in & clear;

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu_iter (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (mdu_start_s),
        .step   (mdu_step_s),
        .flush  (mdu_flush_s),
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .last   (mdu_last_s),
        .result (mdu_res_s)
    );

    // Control FSM with registered result and tag outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= S_IDLE;
            out_valid_r  <= 1'b0;
            out_result_r <= {XLEN{1'b0}};
            out_rs_r     <= {RS_WIDTH{1'b0}};
            out_rob_r    <= {ROB_WIDTH{1'b0}};
            pend_rs_r    <= {RS_WIDTH{1'b0}};
            pend_rob_r   <= {ROB_WIDTH{1'b0}};
        end else if (rdy_in) begin
            if (clear) begin
                // Flush wins over a simultaneous CDB handshake
                state_r     <= S_IDLE;
                out_valid_r <= 1'b0;
            end else begin
                // Handshake retires the current result; a load below may override
                if (out_ready) begin
                    out_valid_r <= 1'b0;
                end
                case (state_r)
                    S_IDLE: begin
                        if (accept_s) begin
                            if (mdu_start_s) begin
                                state_r    <= S_ITER;
                                pend_rs_r  <= in_rs;
                                pend_rob_r <= in_rob;
                            end else begin
                                out_valid_r  <= 1'b1;
                                out_result_r <= fast_res_s;
                                out_rs_r     <= in_rs;
                                out_rob_r    <= in_rob;
                            end
                        end
                    end
                    S_ITER: begin
                        if (mdu_last_s) begin
                            state_r <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (!out_valid_r || out_ready) begin
                            out_valid_r  <= 1'b1;
                            out_result_r <= mdu_res_s;
                            out_rs_r     <= pend_rs_r;
                            out_rob_r    <= pend_rob_r;
                            state_r      <= S_IDLE;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_rs     = out_rs_r;
    assign out_rob    = out_rob_r;

endmodule

// File: tb/tb_exec_unit.sv
`timescale 1ns/1ps
module tb_exec_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_rs;
    logic [3:0]  in_rob;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_rs;
    logic [3:0]  out_rob;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  tag_q  = 4'd0;

    exec_unit #(
        .XLEN      (32),
        .RS_WIDTH  (2),
        .ROB_WIDTH (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rs      (in_rs),
        .in_rob     (in_rob),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rs     (out_rs),
        .out_rob    (out_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk_in);
        #1;
    endtask

    // Issue a single-cycle op and check the result on the following cycle
    task automatic alu_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [3:0] t;
        t        = tag_q;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rs    = t[1:0];
        in_rob   = t;
        #1;
        chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        step_clk();
        chk({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, out_result, exp);
        chk({tag, "/rob"}, {28'd0, out_rob}, {28'd0, t});
        tag_q = tag_q + 4'd1;
    endtask

    // Issue an iterative op, optionally freezing rdy_in for 5 cycles at stall_at
    task automatic mdu_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int stall_at);
        int   lat;
        logic ready_seen;
        logic [3:0] t;
        t          = tag_q;
        lat        = 0;
        ready_seen = 1'b0;
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_rs      = t[1:0];
        in_rob     = t;
        #1;
        chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        step_clk();
        in_valid = 1'b0;
        do begin
            if (lat == stall_at) rdy_in = 1'b0;
            if (lat == stall_at + 5) rdy_in = 1'b1;
            #1;
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk_in);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        rdy_in = 1'b1;
        chk({tag, "/latency"}, lat, exp_lat);
        chk(tag, out_result, exp);
        chk({tag, "/busy_ready"}, {31'd0, ready_seen}, 32'd0);
        chk({tag, "/rs"}, {30'd0, out_rs}, {30'd0, t[1:0]});
        tag_q = tag_q + 4'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vcount;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 5'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_rs     = 2'd0;
        in_rob    = 4'd0;
        out_ready = 1'b1;
        #2;
        chk("reset/in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset/out_result", out_result, 32'd0);
        chk("reset/out_rob", {28'd0, out_rob}, 32'd0);
        step_clk();
        step_clk();
        rst_in = 1'b0;

        // Back-to-back single-cycle ops, including divide special cases
        alu_op("add",     5'd0,  32'd5,         32'd7,         32'd12);
        alu_op("slt",     5'd8,  32'hFFFFFFFF,  32'd1,         32'd1);
        alu_op("sltu",    5'd9,  32'hFFFFFFFF,  32'd1,         32'd0);
        alu_op("sub",     5'd1,  32'd3,         32'd5,         32'hFFFFFFFE);
        alu_op("and",     5'd2,  32'h0000F0F0,  32'h0000FF00,  32'h0000F000);
        alu_op("or",      5'd3,  32'h0000F0F0,  32'h00000F0F,  32'h0000FFFF);
        alu_op("xor",     5'd4,  32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F);
        alu_op("sll",     5'd5,  32'd1,         32'd33,        32'd2);
        alu_op("srl",     5'd6,  32'h80000000,  32'd4,         32'h08000000);
        alu_op("sra",     5'd7,  32'h80000000,  32'd4,         32'hF8000000);
        alu_op("beq",     5'd10, 32'd5,         32'd5,         32'd1);
        alu_op("bge",     5'd11, 32'hFFFFFFFE,  32'd1,         32'd0);
        alu_op("bgeu",    5'd12, 32'hFFFFFFFE,  32'd1,         32'd1);
        alu_op("bne",     5'd13, 32'd5,         32'd5,         32'd0);
        alu_op("add_pc",  5'd14, 32'h00000100,  32'd8,         32'h00000104);
        alu_op("op15",    5'd15, 32'd5,         32'd7,         32'd0);
        alu_op("op24",    5'd24, 32'd5,         32'd7,         32'd0);
        alu_op("div0",    5'd20, 32'd7,         32'd0,         32'hFFFFFFFF);
        alu_op("rem0",    5'd22, 32'd7,         32'd0,         32'd7);
        alu_op("divu0",   5'd21, 32'd7,         32'd0,         32'hFFFFFFFF);
        alu_op("remu0",   5'd23, 32'd7,         32'd0,         32'd7);
        alu_op("div_ovf", 5'd20, 32'h80000000,  32'hFFFFFFFF,  32'h80000000);
        alu_op("rem_ovf", 5'd22, 32'h80000000,  32'hFFFFFFFF,  32'd0);
        in_valid = 1'b0;
        step_clk();
        chk("drain/out_valid", {31'd0, out_valid}, 32'd0);

        // Iterative multiply / divide
        mdu_op("mulh",   5'd17, 32'h80000000, 32'd2,        32'hFFFFFFFF, 33, -1);
        mdu_op("rem_neg",5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, -1);
        mdu_op("div_neg",5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, -1);
        mdu_op("mul",    5'd16, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, -1);
        mdu_op("mulhu",  5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, -1);
        mdu_op("mulhsu", 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, -1);
        mdu_op("divu",   5'd21, 32'd100,      32'd7,        32'd14,       33, -1);
        mdu_op("remu",   5'd23, 32'd100,      32'd7,        32'd2,        33, -1);
        step_clk();

        // Output stall: result held, no accept, one transfer on release
        out_ready = 1'b0;
        alu_op("stall_sub", 5'd1, 32'd3, 32'd5, 32'hFFFFFFFE);
        in_op = 5'd0;
        in_a  = 32'd1;
        in_b  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall/in_ready", {31'd0, in_ready}, 32'd0);
            step_clk();
            chk("stall/valid", {31'd0, out_valid}, 32'd1);
            chk("stall/result", out_result, 32'hFFFFFFFE);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step_clk();
        chk("stall/release", {31'd0, out_valid}, 32'd0);

        // Clear during DIVU iteration aborts it
        in_valid = 1'b1;
        in_op    = 5'd21;
        in_a     = 32'd100;
        in_b     = 32'd7;
        step_clk();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step_clk();
        clear = 1'b1;
        #1;
        chk("clear/in_ready", {31'd0, in_ready}, 32'd0);
        step_clk();
        clear = 1'b0;
        #1;
        chk("clear/out_valid", {31'd0, out_valid}, 32'd0);
        chk("clear/idle", {31'd0, in_ready}, 32'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (out_valid) vcount++;
        end
        chk("clear/no_result", vcount, 32'd0);

        // Freeze mid-MUL delays completion, value unchanged
        mdu_op("mul_frozen", 5'd16, 32'd7, 32'd6, 32'd42, 38, 10);
        step_clk();

        // Asynchronous reset mid-iteration
        in_valid = 1'b1;
        in_op    = 5'd16;
        in_a     = 32'd9;
        in_b     = 32'd9;
        step_clk();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step_clk();
        #2;
        rst_in = 1'b1;
        #1;
        chk("areset/out_result", out_result, 32'd0);
        chk("areset/in_ready", {31'd0, in_ready}, 32'd0);
        step_clk();
        rst_in = 1'b0;
        step_clk();
        chk("areset/idle", {31'd0, in_ready}, 32'd1);
        mdu_op("after_reset", 5'd16, 32'd9, 32'd9, 32'd81, 33, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
